// File: rtl/mvprod_pkg.sv
// Shared types and helpers for the mvprod_lanes matrix-vector engine.
// The MVPROD_BIAS_EN build option changes only the top level; nothing in here depends on it.
package mvprod_pkg;

    typedef logic signed [7:0] int8_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DRAIN  = 3'd2,
        S_WRITE  = 3'd3,
        S_REWIND = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // 16-bit products summed over n terms, plus one guard bit.
    function automatic int acc_width(input int n);
        return 16 + $clog2(n) + 1;
    endfunction

    function automatic int8_t sat8(input logic signed [31:0] v);
        int8_t r;
        if (v > 32'sd127) begin
            r = 8'h7F;
        end else if (v < -32'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mvprod_mac_lane.sv
// One output row: ChunkIn signed multipliers, adder tree, accumulator with clear/enable,
// and the shift-then-saturate requantiser.
module mvprod_mac_lane
    import mvprod_pkg::*;
#(
    parameter int ChunkIn = 2,
    parameter int AccW    = 20,
    parameter int Shift   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic [AccW-1:0]        init_i,
    input  logic                   en_i,
    input  logic [ChunkIn*8-1:0]   x_i,
    input  logic [ChunkIn*8-1:0]   w_i,
    output int8_t                  res_o
);

    logic signed [AccW-1:0] acc_q;
    logic signed [AccW-1:0] acc_d;
    logic signed [AccW-1:0] sum_s;
    logic signed [AccW-1:0] shr_s;
    logic signed [7:0]      xb_s;
    logic signed [7:0]      wb_s;
    logic signed [15:0]     prod_s;

    // Dot product of this chunk against the lane's weights
    always_comb begin
        sum_s  = '0;
        xb_s   = '0;
        wb_s   = '0;
        prod_s = '0;
        for (int k = 0; k < ChunkIn; k++) begin
            xb_s   = x_i[k*8 +: 8];
            wb_s   = w_i[k*8 +: 8];
            prod_s = 16'(xb_s) * 16'(wb_s);
            sum_s  = sum_s + AccW'(prod_s);
        end
    end

    // Accumulator next state: clear wins over accumulate
    always_comb begin
        if (clr_i) begin
            acc_d = init_i;
        end else if (en_i) begin
            acc_d = acc_q + sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Requantise the settled accumulator
    always_comb begin
        shr_s = acc_q >>> Shift;
        res_o = sat8(32'(shr_s));
    end

endmodule

// File: rtl/mvprod_lanes.sv
// int8 matrix-vector product, Lanes rows per pass over a rewindable input FIFO.
// Build option MVPROD_BIAS_EN: preload each row's accumulator from BiasInit.
module mvprod_lanes
    import mvprod_pkg::*;
#(
    parameter int InVecLength  = 8,
    parameter int OutVecLength = 8,
    parameter int ChunkIn      = 2,
    parameter int ChunkOut     = 1,
    parameter int Lanes        = 2,
    parameter int Shift        = 0,
    parameter logic [OutVecLength*InVecLength*8-1:0] WeightInit = '0
`ifdef MVPROD_BIAS_EN
    ,
    parameter logic [OutVecLength*32-1:0] BiasInit = '0
`endif
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  in_data_ready,
    input  logic [ChunkIn*8-1:0]  in_data,
    output logic                  req_chunk_in,
    output logic                  req_chunk_ptr_rst,
    input  logic                  out_ready,
    output logic [ChunkOut*8-1:0] write_out_data,
    output logic                  req_chunk_out,
    output logic                  out_vector_valid
);

    localparam int AccW   = acc_width(InVecLength);
    localparam int NChunk = InVecLength / ChunkIn;
    localparam int NWord  = Lanes / ChunkOut;
    localparam int CntW   = $clog2(NChunk + 1);
    localparam int WrdW   = $clog2(NWord + 1);
    localparam int RbW    = $clog2(OutVecLength + Lanes + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(NChunk - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [WrdW-1:0] WrdLast = WrdW'(NWord - 1);
    localparam logic [WrdW-1:0] WrdOne  = WrdW'(1);
    localparam logic [RbW-1:0]  LanesRb = RbW'(Lanes);
    localparam logic [RbW-1:0]  OutRb   = RbW'(OutVecLength);

    state_t                     state_q;
    logic [CntW-1:0]            cnt_q;
    logic [WrdW-1:0]            word_q;
    logic [RbW-1:0]             row_base_q;
    logic                       vld_q;
    logic                       ptr_rst_q;
    logic                       done_q;
    logic [Lanes*ChunkIn*8-1:0] w_word_q;

    logic                       req_in_s;
    logic                       req_out_s;
    logic                       clr_s;
    logic [RbW-1:0]             next_base_s;
    logic [RbW-1:0]             clr_base_s;
    logic [AccW-1:0]            init_s [Lanes];
    int8_t                      lane_res_s [Lanes];

    // Strobes follow the handshake inputs in the same cycle
    always_comb begin
        req_in_s    = (state_q == S_LOAD) && in_data_ready;
        req_out_s   = (state_q == S_WRITE) && out_ready;
        next_base_s = row_base_q + LanesRb;
        if (state_q == S_IDLE) begin
            clr_s      = in_data_ready;
            clr_base_s = row_base_q;
        end else if (state_q == S_REWIND) begin
            clr_s      = (next_base_s < OutRb);
            clr_base_s = next_base_s;
        end else begin
            clr_s      = 1'b0;
            clr_base_s = row_base_q;
        end
    end

    // Accumulator start value for the pass about to begin
    always_comb begin
        for (int l = 0; l < Lanes; l++) begin
`ifdef MVPROD_BIAS_EN
            init_s[l] = BiasInit[(int'(clr_base_s) + l)*32 +: AccW];
`else
            init_s[l] = '0;
`endif
        end
    end

    // Weight ROM: one registered word per {pass, chunk}, aligned with in_data
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            w_word_q <= '0;
        end else if (req_in_s) begin
            for (int l = 0; l < Lanes; l++) begin
                for (int k = 0; k < ChunkIn; k++) begin
                    w_word_q[(l*ChunkIn + k)*8 +: 8] <=
                        WeightInit[((int'(row_base_q) + l)*InVecLength + int'(cnt_q)*ChunkIn + k)*8 +: 8];
                end
            end
        end else begin
            w_word_q <= w_word_q;
        end
    end

    // Pass sequencing: fetch chunks, drain, emit words, rewind, finish
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            row_base_q <= '0;
            vld_q      <= 1'b0;
            ptr_rst_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            vld_q     <= req_in_s;
            ptr_rst_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (in_data_ready) begin
                        state_q <= S_LOAD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (in_data_ready) begin
                        if (cnt_q == CntLast) begin
                            cnt_q   <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                S_DRAIN: begin
                    word_q  <= '0;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (out_ready) begin
                        if (word_q == WrdLast) begin
                            word_q    <= '0;
                            ptr_rst_q <= 1'b1;
                            state_q   <= S_REWIND;
                        end else begin
                            word_q <= word_q + WrdOne;
                        end
                    end else begin
                        word_q <= word_q;
                    end
                end
                S_REWIND: begin
                    row_base_q <= next_base_s;
                    if (next_base_s < OutRb) begin
                        state_q <= S_LOAD;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    row_base_q <= '0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar l = 0; l < Lanes; l++) begin : g_lane
        mvprod_mac_lane #(
            .ChunkIn (ChunkIn),
            .AccW    (AccW),
            .Shift   (Shift)
        ) u_lane (
            .clk_i  (clk_in),
            .rst_i  (rst_in),
            .clr_i  (clr_s),
            .init_i (init_s[l]),
            .en_i   (vld_q),
            .x_i    (in_data),
            .w_i    (w_word_q[l*ChunkIn*8 +: ChunkIn*8]),
            .res_o  (lane_res_s[l])
        );
    end

    // Output word select: lowest-index row of the word lands in byte 0
    always_comb begin
        write_out_data = '0;
        for (int j = 0; j < ChunkOut; j++) begin
            write_out_data[j*8 +: 8] = lane_res_s[int'(word_q)*ChunkOut + j];
        end
    end

    assign req_chunk_in      = req_in_s;
    assign req_chunk_out     = req_out_s;
    assign req_chunk_ptr_rst = ptr_rst_q;
    assign out_vector_valid  = done_q;

endmodule

// File: tb/tb_mvprod_lanes.sv
// Scoreboard bench for mvprod_lanes: four weight/shift configurations, each fed by a
// small rewindable FIFO model; one active instance at a time.
module tb_mvprod_lanes;

    localparam int BIAS =
`ifdef MVPROD_BIAS_EN
        1;
`else
        0;
`endif

    function automatic logic [511:0] mkw(input int kind);
        logic [511:0] w = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (kind == 0) w[(r*8+c)*8 +: 8] = (r == c) ? 8'h01 : 8'h00;
                else if (kind == 1) w[(r*8+c)*8 +: 8] = 8'h7F;
                else w[(r*8+c)*8 +: 8] = 8'h80;
            end
        end
        return w;
    endfunction

    function automatic logic [255:0] mkb(input int kind);
        logic [255:0] b = '0;
        for (int r = 0; r < 8; r++) b[r*32 +: 32] = (kind == 0) ? 32'(r) : 32'd0;
        return b;
    endfunction

    function automatic int sat(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]      rdy_v = '0;
    logic            tog_en = 1'b0;
    logic            tog_q = 1'b0;
    logic            out_rdy;
    logic [7:0]      xmem [8];
    logic [3:0]      rqi_v, ptr_v, wr_v, val_v;
    logic [3:0][7:0] dout_v;

    always @(posedge clk) tog_q <= ~tog_q;
    assign out_rdy = tog_en ? tog_q : 1'b1;

    for (genvar g = 0; g < 4; g++) begin : g_inst
        logic [15:0] din;
        logic [7:0]  dout;
        logic        rqi, prst, wro, vv;
        logic [1:0]  rp;

        always @(posedge clk) begin
            if (rst) begin
                rp  <= 2'd0;
                din <= 16'd0;
            end else if (prst) begin
                rp <= 2'd0;
            end else if (rqi) begin
                din <= {xmem[2*rp+1], xmem[2*rp]};
                rp  <= rp + 2'd1;
            end
        end

        mvprod_lanes #(
            .InVecLength(8), .OutVecLength(8), .ChunkIn(2), .ChunkOut(1), .Lanes(2),
            .Shift((g == 3) ? 7 : 0), .WeightInit(mkw(g))
`ifdef MVPROD_BIAS_EN
            , .BiasInit(mkb(g))
`endif
        ) u_dut (
            .clk_in(clk), .rst_in(rst), .in_data_ready(rdy_v[g]), .in_data(din),
            .req_chunk_in(rqi), .req_chunk_ptr_rst(prst), .out_ready(out_rdy),
            .write_out_data(dout), .req_chunk_out(wro), .out_vector_valid(vv)
        );

        assign rqi_v[g]  = rqi;
        assign ptr_v[g]  = prst;
        assign wr_v[g]   = wro;
        assign val_v[g]  = vv;
        assign dout_v[g] = dout;
    end

    int total = 0, bad = 0;
    int sel = 0, exp_lat = -1;
    int cyc = 0, n_req = 0, n_ptr = 0, n_wr = 0, first_req = 0, done_cnt = 0;
    int exp_q [$];

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every write and audits each finished vector
    initial begin
        bit rst_prev = 1'b1;
        int e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (rst_prev) chk("reset_outputs", longint'({rqi_v, ptr_v, wr_v, val_v, dout_v}), 0);
                n_req = 0; n_ptr = 0; n_wr = 0;
            end else begin
                if (rqi_v[sel]) begin
                    if (n_req == 0) first_req = cyc;
                    n_req++;
                end
                if (ptr_v[sel]) n_ptr++;
                if (wr_v[sel]) begin
                    n_wr++;
                    chk("write_needs_ready", out_rdy, 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_byte", int'($signed(dout_v[sel])), e);
                    end
                end
                if (val_v[sel]) begin
                    chk("req_in_count", n_req, 16);
                    chk("ptr_rst_count", n_ptr, 4);
                    chk("write_count", n_wr, 8);
                    chk("queue_left", exp_q.size(), 0);
                    if (exp_lat >= 0) chk("latency", cyc - first_req, exp_lat);
                    n_req = 0; n_ptr = 0; n_wr = 0;
                    done_cnt++;
                end
            end
            rst_prev = rst;
        end
    end

    task automatic set_x(input logic [63:0] p);
        for (int i = 0; i < 8; i++) xmem[i] = p[i*8 +: 8];
    endtask

    task automatic push_exp(input int inst);
        for (int i = 0; i < 8; i++) begin
            if (inst == 0) exp_q.push_back(sat(int'($signed(xmem[i])) + BIAS*i));
            else if (inst == 1) exp_q.push_back(127);
            else exp_q.push_back(-128);
        end
    endtask

    task automatic run_vec(input int inst, input int lat, input bit drop);
        int d0 = done_cnt;
        int guard = 0;
        sel = inst;
        exp_lat = lat;
        push_exp(inst);
        @(posedge clk); #1;
        rdy_v[inst] = 1'b1;
        if (drop) begin
            while (n_req < 2 && guard < 500) begin @(posedge clk); guard++; end
            #1 rdy_v[inst] = 1'b0;
            repeat (3) @(posedge clk);
            #1 rdy_v[inst] = 1'b1;
        end
        guard = 0;
        while (done_cnt == d0 && guard < 2000) begin @(posedge clk); guard++; end
        if (done_cnt == d0) begin
            $display("FAIL timeout: no out_vector_valid from instance %0d", inst);
            $fatal(1, "timeout");
        end
        #1 rdy_v[inst] = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int guard = 0;
        set_x(64'h0706050403020100);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_vec(0, 32, 1'b0);                 // identity, x = 0..7
        set_x(64'h4000FF037F8064FB);
        tog_en = 1'b1;
        run_vec(0, -1, 1'b0);                 // mixed signs under backpressure
        tog_en = 1'b0;
        set_x(64'h0706050403020100);
        run_vec(0, 35, 1'b1);                 // in_data_ready dropped for 3 cycles
        set_x(64'h7F7F7F7F7F7F7F7F);
        run_vec(1, 32, 1'b0);                 // positive saturation
        run_vec(2, 32, 1'b0);                 // negative saturation
        run_vec(3, 32, 1'b0);                 // -1016 after shift, still saturates

        // Reset in the middle of the first WRITE, then a clean vector
        set_x(64'h0706050403020100);
        sel = 0;
        push_exp(0);
        @(posedge clk); #1 rdy_v[0] = 1'b1;
        while (n_wr < 1 && guard < 500) begin @(posedge clk); guard++; end
        #1 rst = 1'b1;
        rdy_v[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        run_vec(0, 32, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
